// File: rtl/dma_engine.sv
// dma_engine: moves 32-bit words between a fixed I/O address and an incrementing memory address, then raises a sticky irq.
// Ports: clk/reset (async, active-low); start, control (bit1 dir, [LEN_W+15:16] count), io_address, mem_address: transfer setup;
// abort: stop at the next granted write; irq_clr: clears irq/aborted; bus_*: request/grant master; busy/remaining/irq/aborted: status.
module dma_engine #(
  parameter int WIDTH_p = 32,
  parameter int LEN_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH_p-1:0] control,
  input  logic [WIDTH_p-1:0] io_address,
  input  logic [WIDTH_p-1:0] mem_address,
  input  logic               abort,
  input  logic               irq_clr,
  output logic               bus_req,
  output logic               bus_we,
  output logic [WIDTH_p-1:0] bus_addr,
  output logic [WIDTH_p-1:0] bus_wdata,
  input  logic               bus_gnt,
  input  logic               bus_rvalid,
  input  logic [WIDTH_p-1:0] bus_rdata,
  output logic               busy,
  output logic [LEN_W-1:0]   remaining,
  output logic               irq,
  output logic               aborted
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE} state_t;
  state_t state, state_d;
  logic dir, dir_d, irq_d, ab_d;
  logic [WIDTH_p-1:0] src, src_d, dst, dst_d, data, data_d, addr_d, wdata_d;
  logic [LEN_W-1:0] rem_d, cnt;
  logic unused_ok;
  assign cnt = control[LEN_W+15:16];
  assign unused_ok = ^{control[15:2], control[0]};
  always_comb begin
    state_d = state;
    dir_d = dir;
    src_d = src;
    dst_d = dst;
    data_d = data;
    rem_d = remaining;
    irq_d = irq & ~irq_clr;
    ab_d = aborted & ~irq_clr;
    case (state)
      IDLE: if (start) begin
        dir_d = control[1];
        src_d = control[1] ? mem_address : io_address;
        dst_d = control[1] ? io_address : mem_address;
        rem_d = cnt;
        state_d = cnt != '0 ? RD_REQ : DONE;
      end
      RD_REQ: state_d = bus_gnt ? RD_WAIT : RD_REQ;
      RD_WAIT: if (bus_rvalid) begin
        data_d = bus_rdata;
        state_d = WR_REQ;
      end
      WR_REQ: if (bus_gnt) begin
        rem_d = remaining - 1'b1;
        src_d = dir ? src + WIDTH_p'(4) : src;
        dst_d = dir ? dst : dst + WIDTH_p'(4);
        state_d = (rem_d == '0 || abort) ? DONE : RD_REQ;
        ab_d = (rem_d != '0 && abort) ? 1'b1 : ab_d;
      end
      DONE: begin
        irq_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // Bus outputs are registered from the next state so they are valid in the first request cycle and hold until grant.
  assign addr_d = state_d == RD_REQ ? src_d : state_d == WR_REQ ? dst_d : bus_addr;
  assign wdata_d = state_d == WR_REQ ? data_d : bus_wdata;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      dir <= 1'b0;
      src <= '0;
      dst <= '0;
      data <= '0;
      remaining <= '0;
      irq <= 1'b0;
      aborted <= 1'b0;
      bus_req <= 1'b0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_wdata <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_d;
      dir <= dir_d;
      src <= src_d;
      dst <= dst_d;
      data <= data_d;
      remaining <= rem_d;
      irq <= irq_d;
      aborted <= ab_d;
      bus_req <= state_d == RD_REQ || state_d == WR_REQ;
      bus_we <= state_d == WR_REQ;
      bus_addr <= addr_d;
      bus_wdata <= wdata_d;
      busy <= state_d != IDLE;
    end
  end
endmodule
